// File: rtl/req_age_pkg.sv
// Request aging controller: shared state encoding and default sizing.
// Imported by the interface, the per-client slot and the top.
package req_age_pkg;

  localparam int DEF_N         = 8;
  localparam int DEF_AGE_W     = 4;
  localparam int DEF_AGE_LIMIT = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_URGENT,
    ST_BUSY
  } state_t;

endpackage

// File: rtl/req_age_ctrl_if.sv
// Client/arbiter bundle for the request aging controller.
// master drives requests and arbiter feedback, slave is the controller.
interface req_age_ctrl_if
  import req_age_pkg::*;
#(
  parameter int N = DEF_N
);

  logic [N-1:0] req;
  logic [N-1:0] sel;
  logic         sel_valid;
  logic         sel_valid_urgent;
  logic         gnt_ack;
  logic [N-1:0] done;
  logic         clr_err;
  logic [N-1:0] ready;
  logic [N-1:0] ready_urgent;
  logic [N-1:0] busy;
  logic [N-1:0] starve;
  logic         grant_err;

  modport master (
    output req, sel, sel_valid, sel_valid_urgent,
    output gnt_ack, done, clr_err,
    input  ready, ready_urgent, busy, starve, grant_err
  );

  modport slave (
    input  req, sel, sel_valid, sel_valid_urgent,
    input  gnt_ack, done, clr_err,
    output ready, ready_urgent, busy, starve, grant_err
  );

endinterface

// File: rtl/req_age_slot.sv
// One client: request FSM, saturating age counter and sticky starve flag.
// gnt is already qualified by the top, so a bad grant never reaches here.
module req_age_slot
  import req_age_pkg::*;
#(
  parameter int AGE_W     = DEF_AGE_W,
  parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  input  logic done,
  input  logic clr_err,
  output logic ready,
  output logic ready_urgent,
  output logic busy,
  output logic starve
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  state_t           state;
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] age_inc;

  assign age_inc = age + AGE_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      age    <= '0;
      starve <= 1'b0;
    end else begin
      // set below overrides this clear on the same edge
      if (clr_err) starve <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_WAIT;
            age   <= '0;
          end
        end
        ST_WAIT: begin
          if (gnt) state <= ST_BUSY;
          else if (!req) state <= ST_IDLE;
          else begin
            age <= age_inc;
            if (age_inc == AGE_LIM) state <= ST_URGENT;
          end
        end
        ST_URGENT: begin
          if (gnt) state <= ST_BUSY;
          else if (!req) state <= ST_IDLE;
          else if (age != AGE_MAX) begin
            age <= age_inc;
            if (age_inc == AGE_MAX) starve <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (done) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready        = (state == ST_WAIT);
  assign ready_urgent = (state == ST_URGENT);
  assign busy         = (state == ST_BUSY);

endmodule

// File: rtl/req_age_ctrl.sv
// Request aging controller: N client slots plus grant qualification
// and the sticky protocol-error flag.
module req_age_ctrl
  import req_age_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int AGE_W     = DEF_AGE_W,
  parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
  input logic           clk,
  input logic           rst,
  req_age_ctrl_if.slave bus
);

  localparam logic [N-1:0] SEL_ONE = N'(1);

  logic         any_vld;
  logic         one_hot;
  logic         tgt_ok;
  logic         bad;
  logic         grant_err;
  logic [N-1:0] pend;
  logic [N-1:0] gnt;
  logic [N-1:0] rdy;
  logic [N-1:0] urg;
  logic [N-1:0] bsy;
  logic [N-1:0] stv;

  assign any_vld = bus.gnt_ack &
                   (bus.sel_valid | bus.sel_valid_urgent);
  assign one_hot = (bus.sel != '0) &&
                   ((bus.sel & (bus.sel - SEL_ONE)) == '0);
  assign pend    = rdy | urg;
  assign tgt_ok  = |(bus.sel & pend);
  assign bad     = any_vld & ~(one_hot & tgt_ok);
  // an offending selection is dropped, so no slot sees it
  assign gnt     = (any_vld & ~bad) ? bus.sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_err <= 1'b0;
    end else if (bad) begin
      grant_err <= 1'b1;
    end else if (bus.clr_err) begin
      grant_err <= 1'b0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    req_age_slot #(
      .AGE_W     (AGE_W),
      .AGE_LIMIT (AGE_LIMIT)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .req          (bus.req[i]),
      .gnt          (gnt[i]),
      .done         (bus.done[i]),
      .clr_err      (bus.clr_err),
      .ready        (rdy[i]),
      .ready_urgent (urg[i]),
      .busy         (bsy[i]),
      .starve       (stv[i])
    );
  end

  assign bus.ready        = rdy;
  assign bus.ready_urgent = urg;
  assign bus.busy         = bsy;
  assign bus.starve       = stv;
  assign bus.grant_err    = grant_err;

endmodule

// File: tb/tb_req_age_ctrl.sv
// Scoreboard bench for req_age_ctrl: a wait-count model predicts
// every cycle's outputs, a monitor compares after each clock edge.
module tb_req_age_ctrl;

  localparam int N         = 8;
  localparam int AGE_W     = 4;
  localparam int AGE_LIMIT = 10;
  localparam int SAT       = (1 << AGE_W) - 1;

  typedef struct {
    logic [N-1:0] rdy;
    logic [N-1:0] urg;
    logic [N-1:0] bsy;
    logic [N-1:0] stv;
    logic         gerr;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  req_age_ctrl_if #(.N(N)) bus ();

  req_age_ctrl #(
    .N         (N),
    .AGE_W     (AGE_W),
    .AGE_LIMIT (AGE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // model: pending/busy flags and plain count of cycles waited
  bit   m_pend[N];
  bit   m_busy[N];
  bit   m_stv[N];
  int   m_wait[N];
  bit   m_gerr;

  function automatic exp_t model_out();
    exp_t e;
    e.rdy  = '0;
    e.urg  = '0;
    e.bsy  = '0;
    e.stv  = '0;
    e.gerr = m_gerr;
    e.cyc  = cyc;
    for (int i = 0; i < N; i++) begin
      e.rdy[i] = m_pend[i] && (m_wait[i] < AGE_LIMIT);
      e.urg[i] = m_pend[i] && (m_wait[i] >= AGE_LIMIT);
      e.bsy[i] = m_busy[i];
      e.stv[i] = m_stv[i];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_busy[i] = 0;
      m_stv[i]  = 0;
      m_wait[i] = 0;
    end
    m_gerr = 0;
  endtask

  task automatic check(string nm, exp_t e);
    tests++;
    if (bus.ready !== e.rdy || bus.ready_urgent !== e.urg ||
        bus.busy !== e.bsy || bus.starve !== e.stv ||
        bus.grant_err !== e.gerr) begin
      fails++;
      $display("FAIL %s cyc=%0d got rdy=%h urg=%h bsy=%h stv=%h err=%b exp rdy=%h urg=%h bsy=%h stv=%h err=%b",
               nm, e.cyc, bus.ready, bus.ready_urgent, bus.busy,
               bus.starve, bus.grant_err, e.rdy, e.urg, e.bsy,
               e.stv, e.gerr);
    end
  endtask

  task automatic model_step();
    bit any;
    bit ok;
    bit clr;
    int k;
    any = bus.gnt_ack && (bus.sel_valid || bus.sel_valid_urgent);
    clr = bus.clr_err;
    ok  = 0;
    if ($countones(bus.sel) == 1) begin
      k = 0;
      for (int i = 0; i < N; i++) if (bus.sel[i]) k = i;
      ok = m_pend[k];
    end
    m_gerr = (m_gerr && !clr) || (any && !ok);
    for (int i = 0; i < N; i++) begin
      bit g;
      bit st_set;
      g      = any && ok && bus.sel[i];
      st_set = 0;
      if (m_busy[i]) begin
        if (bus.done[i]) m_busy[i] = 0;
      end else if (m_pend[i]) begin
        if (g) begin
          m_busy[i] = 1;
          m_pend[i] = 0;
        end else if (!bus.req[i]) begin
          m_pend[i] = 0;
        end else begin
          m_wait[i]++;
          if (m_wait[i] == SAT) st_set = 1;
        end
      end else if (bus.req[i]) begin
        m_pend[i] = 1;
        m_wait[i] = 0;
      end
      m_stv[i] = (m_stv[i] && !clr) || st_set;
    end
  endtask

  // called at a falling edge with inputs already applied
  task automatic step();
    model_step();
    sb.push_back(model_out());
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req              = '0;
    bus.sel              = '0;
    bus.sel_valid        = 1'b0;
    bus.sel_valid_urgent = 1'b0;
    bus.gnt_ack          = 1'b0;
    bus.done             = '0;
    bus.clr_err          = 1'b0;
  endtask

  task automatic grant(int k);
    logic [N-1:0] one;
    one           = 1;
    bus.sel       = one << k;
    bus.sel_valid = 1'b1;
    bus.gnt_ack   = 1'b1;
  endtask

  task automatic rand_inputs();
    logic [N-1:0] r;
    logic [N-1:0] d;
    logic [N-1:0] one;
    int           pl[$];
    int           m;
    one = 1;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        r[i] = 1'($urandom_range(0, 1));
        d[i] = ($urandom_range(0, 2) == 0);
      end else if (m_pend[i]) begin
        r[i] = ($urandom_range(0, 19) != 0);
        d[i] = ($urandom_range(0, 7) == 0);
        pl.push_back(i);
      end else begin
        r[i] = ($urandom_range(0, 3) == 0);
        d[i] = ($urandom_range(0, 7) == 0);
      end
    end
    bus.req  = r;
    bus.done = d;
    m = $urandom_range(0, 9);
    if (m < 6 && pl.size() > 0)
      bus.sel = one << pl[$urandom_range(0, pl.size() - 1)];
    else if (m == 6)
      bus.sel = N'($urandom);
    else if (m == 7)
      bus.sel = one << $urandom_range(0, N - 1);
    else
      bus.sel = '0;
    bus.sel_valid        = 1'($urandom_range(0, 1));
    bus.sel_valid_urgent = 1'($urandom_range(0, 1));
    bus.gnt_ack          = ($urandom_range(0, 2) == 0);
    bus.clr_err          = ($urandom_range(0, 15) == 0);
  endtask

  // async reset at a falling edge; checked before the next rising edge
  task automatic async_reset(string nm);
    rst = 1'b1;
    #1;
    model_reset();
    check(nm, model_out());
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cycle", e);
    end
  end

  initial begin
    bit any_busy;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    check("reset", model_out());
    @(negedge clk);
    rst = 1'b0;

    // aging to urgent and starvation, then clear keeps urgency
    bus.req = 8'h24;
    for (int i = 0; i < 18; i++) step();
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    step();
    step();
    idle_inputs();
    step();

    // grant with simultaneous withdrawal, then completion
    bus.req = 8'h01;
    step();
    bus.req = 8'h00;
    grant(0);
    step();
    idle_inputs();
    step();
    bus.done = 8'h01;
    step();
    idle_inputs();
    step();

    // bad grants: multi-hot, idle target, then clear
    bus.req = 8'h02;
    step();
    bus.sel         = 8'h03;
    bus.sel_valid   = 1'b1;
    bus.gnt_ack     = 1'b1;
    step();
    bus.sel         = 8'h10;
    step();
    bus.gnt_ack     = 1'b0;
    bus.clr_err     = 1'b1;
    step();
    bus.clr_err     = 1'b0;
    bus.sel         = 8'h02;
    step();
    idle_inputs();
    step();

    // reset while a client is busy
    bus.req = 8'h08;
    step();
    grant(3);
    step();
    idle_inputs();
    step();
    async_reset("rst_busy");
    step();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
      if (n % 500 == 250) begin
        any_busy = 0;
        for (int i = 0; i < N; i++) any_busy |= m_busy[i];
        if (any_busy) async_reset("rst_rand");
      end
    end

    idle_inputs();
    step();
    @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d left exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
